// File: rtl/freq_meter.sv
// ---------------------------------------------------------------------------
// freq_meter
//   Gated frequency counter. Counts rising edges of an asynchronous input
//   over a window of GATE_CYCLES system-clock cycles. At the end of the
//   window it reports the total, saturated at 2^COUNT_W-1, with a one-cycle
//   valid strobe. Windows can be single-shot or back-to-back (continuous).
//
// Ports
//   clk_in      : system clock, all logic on its rising edge
//   rst         : asynchronous active-high reset
//   sig_in      : signal to measure, asynchronous to clk_in
//   start       : request a measurement (sampled in IDLE only)
//   continuous  : repeat windows back-to-back (sampled on last window cycle)
//   count       : rising edges counted in the last completed window
//   count_valid : one-cycle strobe, count/overflow updated this cycle
//   busy        : high while synchronizing or measuring
//   overflow    : last window's edge total exceeded 2^COUNT_W-1
// ---------------------------------------------------------------------------
module freq_meter #(
    parameter int GATE_CYCLES = 50000000,
    parameter int COUNT_W     = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               sig_in,
    input  logic               start,
    input  logic               continuous,
    output logic [COUNT_W-1:0] count,
    output logic               count_valid,
    output logic               busy,
    output logic               overflow
);

    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int WAIT_W = (SYNC_STAGES > 1) ? $clog2(SYNC_STAGES) : 1;

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SYNC_STAGES - 1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_SYNC_WAIT = 2'd1;
    localparam logic [1:0] ST_MEASURE   = 2'd2;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_prev;
    logic [1:0]             r_state;
    logic [WAIT_W-1:0]      r_wait;
    logic [GATE_W-1:0]      r_gate;
    logic [COUNT_W-1:0]     r_acc;
    logic                   r_ovf;
    logic [COUNT_W-1:0]     r_count;
    logic                   r_count_valid;
    logic                   r_overflow;

    logic                   w_s_sync;
    logic                   w_edge;
    logic                   w_acc_sat;
    logic [COUNT_W-1:0]     w_acc_next;
    logic                   w_ovf_next;
    logic                   w_gate_last;

    assign w_s_sync = r_sync[SYNC_STAGES-1];

    // Accumulator and overflow flag as they would be after this cycle's edge.
    // Used both for normal accumulation and for the result on the last cycle,
    // so the final-cycle edge is never lost.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_edge      = 1'b0;
        w_acc_sat   = 1'b0;
        w_acc_next  = r_acc;
        w_ovf_next  = r_ovf;
        w_gate_last = 1'b0;

        w_edge      = w_s_sync & ~r_s_prev;
        w_acc_sat   = (r_acc == {COUNT_W{1'b1}});
        w_gate_last = (r_gate == GATE_LAST);
        if (w_edge && !w_acc_sat) begin
            w_acc_next = r_acc + 1'b1;
        end
        if (w_edge && w_acc_sat) begin
            w_ovf_next = 1'b1;
        end
    end

    // Synchronizer and edge register run in every state, so s_prev follows
    // the input during SYNC_WAIT and a level already high at start is not
    // mistaken for an edge.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_sync   <= '0;
            r_s_prev <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_s_prev <= w_s_sync;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_wait        <= '0;
            r_gate        <= '0;
            r_acc         <= '0;
            r_ovf         <= 1'b0;
            r_count       <= '0;
            r_count_valid <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_count_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_SYNC_WAIT;
                        r_wait  <= '0;
                        r_gate  <= '0;
                        r_acc   <= '0;
                        r_ovf   <= 1'b0;
                    end
                end

                // Let the synchronizer flush stale samples before counting.
                ST_SYNC_WAIT: begin
                    if (r_wait == WAIT_LAST) begin
                        r_state <= ST_MEASURE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end

                ST_MEASURE: begin
                    if (w_gate_last) begin
                        r_count       <= w_acc_next;
                        r_overflow    <= w_ovf_next;
                        r_count_valid <= 1'b1;
                        r_gate        <= '0;
                        r_acc         <= '0;
                        r_ovf         <= 1'b0;
                        // Staying in MEASURE with cleared counters gives a
                        // new window with no dead cycle in between.
                        r_state       <= continuous ? ST_MEASURE : ST_IDLE;
                    end else begin
                        r_gate <= r_gate + 1'b1;
                        r_acc  <= w_acc_next;
                        r_ovf  <= w_ovf_next;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign count       = r_count;
    assign count_valid = r_count_valid;
    assign overflow    = r_overflow;
    assign busy        = (r_state != ST_IDLE);

endmodule
